// File: rtl/monitor_sequencia.sv
// monitor_sequencia: locks onto the mod-6 step sequence 0..5,0,... and reports
// the current step, completed cycles and sequence violations.
module monitor_sequencia #(
    parameter int CONF_N = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] bits_in,
    input  logic       en,
    output logic [5:0] passo,
    output logic       travado,
    output logic       erro,
    output logic [7:0] ciclos,
    output logic [3:0] falhas
);
    typedef enum logic [1:0] {BUSCA, CONFIRMA, TRAVADO} state_t;
    localparam logic [2:0] CONF_W = 3'(CONF_N);
    state_t     state_q, state_d;
    logic [2:0] ref_q, ref_d, conf_q, conf_d, succ;
    logic [7:0] ciclos_d;
    logic [3:0] falhas_d;
    logic       erro_d, valid, hit;
    assign valid = bits_in < 3'd6;
    assign succ  = (ref_q == 3'd5) ? 3'd0 : ref_q + 3'd1;
    assign hit   = bits_in == succ;
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        conf_d   = conf_q;
        ciclos_d = ciclos;
        falhas_d = falhas;
        erro_d   = 1'b0;
        if (en) begin
            case (state_q)
                BUSCA: begin
                    if (valid) begin
                        ref_d   = bits_in;
                        conf_d  = 3'd0;
                        state_d = CONFIRMA;
                    end
                end
                CONFIRMA: begin
                    if (hit) begin
                        ref_d   = bits_in;
                        conf_d  = conf_q + 3'd1;
                        state_d = (conf_d == CONF_W) ? TRAVADO : CONFIRMA;
                    end else if (valid) begin
                        ref_d  = bits_in;
                        conf_d = 3'd0;
                    end else begin
                        state_d = BUSCA;
                    end
                end
                TRAVADO: begin
                    if (hit) begin
                        ref_d    = bits_in;
                        ciclos_d = (bits_in == 3'd0) ? ciclos + 8'd1 : ciclos;
                    end else begin
                        // violating sample is dropped; search restarts on the next one
                        erro_d   = 1'b1;
                        falhas_d = (falhas == 4'hf) ? falhas : falhas + 4'd1;
                        state_d  = BUSCA;
                    end
                end
                default: state_d = BUSCA;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BUSCA;
            ref_q   <= 3'd0;
            conf_q  <= 3'd0;
            passo   <= 6'd0;
            travado <= 1'b0;
            erro    <= 1'b0;
            ciclos  <= 8'd0;
            falhas  <= 4'd0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            conf_q  <= conf_d;
            passo   <= (state_d == TRAVADO) ? 6'd1 << ref_d : 6'd0;
            travado <= state_d == TRAVADO;
            erro    <= erro_d;
            ciclos  <= ciclos_d;
            falhas  <= falhas_d;
        end
    end
endmodule

// File: tb/tb_monitor_sequencia.sv
// tb_monitor_sequencia: scenario tasks plus randomized traffic checked against
// a sample-history model of the step monitor.
module tb_monitor_sequencia;
    localparam int CONF_N = 3;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] bits_in = 3'd0;
    logic [5:0] passo;
    logic       travado, erro;
    logic [7:0] ciclos;
    logic [3:0] falhas;
    int checks = 0;
    int errors = 0;

    monitor_sequencia #(.CONF_N(CONF_N)) dut (
        .clock(clock), .reset(reset), .bits_in(bits_in), .en(en),
        .passo(passo), .travado(travado), .erro(erro), .ciclos(ciclos), .falhas(falhas)
    );

    always #5 clock = ~clock;

    // model: locked flag, last accepted code, length of the current correct run
    bit m_locked, m_run_valid, m_err;
    int m_ref, m_run, m_cyc, m_fail;

    task automatic model_step(input bit e, input int b, input bit r);
        if (r) begin
            m_locked = 0; m_run_valid = 0; m_err = 0;
            m_ref = 0; m_run = 0; m_cyc = 0; m_fail = 0;
            return;
        end
        m_err = 0;
        if (!e) return;
        if (m_locked) begin
            if (b == (m_ref + 1) % 6) begin
                m_ref = b;
                if (b == 0) m_cyc = (m_cyc + 1) % 256;
            end else begin
                m_err = 1;
                m_fail = (m_fail < 15) ? m_fail + 1 : 15;
                m_locked = 0;
                m_run_valid = 0;
            end
        end else if (m_run_valid && b == (m_ref + 1) % 6) begin
            m_ref = b;
            m_run++;
            if (m_run == CONF_N) m_locked = 1;
        end else if (b < 6) begin
            m_ref = b; m_run = 0; m_run_valid = 1;
        end else begin
            m_run_valid = 0;
        end
    endtask

    function automatic logic [19:0] exp_vec();
        logic [5:0] p;
        p = m_locked ? 6'(1 << m_ref) : 6'd0;
        return {p, m_locked, m_err, 8'(m_cyc), 4'(m_fail)};
    endfunction

    task automatic cyc(input bit e, input int b, input bit r);
        @(negedge clock);
        en = e; bits_in = 3'(b); reset = r;
        @(posedge clock);
        model_step(e, b, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 3, 1);
        checks++;
        if ({passo, travado, erro, ciclos, falhas} !== 20'd0) begin
            errors++; $display("FAIL reset got %h exp 0", {passo, travado, erro, ciclos, falhas});
        end
    endtask

    task automatic test_sequence();
        int seq[7] = '{0, 1, 2, 3, 4, 5, 0};
        logic [5:0] pexp[7] = '{6'd0, 6'd0, 6'd0, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
        cyc(0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1, seq[i], 0);
            checks++;
            if (passo !== pexp[i] || travado !== (i >= 3) || erro !== 1'b0) begin
                errors++; $display("FAIL seq[%0d] passo %b trav %b erro %b exp %b %b 0", i, passo, travado, erro, pexp[i], i >= 3);
            end
        end
        checks++;
        if (ciclos !== 8'd1 || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
            errors++; $display("FAIL seq_ciclos got %0d exp 1", ciclos);
        end
    endtask

    task automatic test_invalid_locked();
        cyc(0, 0, 1);
        for (int b = 5; b != 3; b = (b + 1) % 6) cyc(1, b, 0);
        checks++;
        if (travado !== 1'b1 || passo !== 6'b000100) begin
            errors++; $display("FAIL lock_ref2 trav %b passo %b exp 1 000100", travado, passo);
        end
        cyc(1, 7, 0);
        checks++;
        if ({erro, falhas, travado, passo} !== {1'b1, 4'd1, 1'b0, 6'd0}) begin
            errors++; $display("FAIL invalid_locked erro %b falhas %0d trav %b passo %b exp 1 1 0 0", erro, falhas, travado, passo);
        end
        cyc(0, 7, 0);
        checks++;
        if (erro !== 1'b0 || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
            errors++; $display("FAIL erro_pulse got %b exp 0", erro);
        end
    endtask

    task automatic test_skip_relock();
        int seq[5] = '{0, 1, 2, 3, 3};
        cyc(0, 0, 1);
        for (int b = 5; b != 3; b = (b + 1) % 6) cyc(1, b, 0);
        cyc(1, 4, 0);
        checks++;
        if (erro !== 1'b1 || falhas !== 4'd1 || travado !== 1'b0) begin
            errors++; $display("FAIL skip erro %b falhas %0d trav %b exp 1 1 0", erro, falhas, travado);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq[i], 0);
            checks++;
            if (travado !== (i == 3) || erro !== 1'b0 || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
                errors++; $display("FAIL relock[%0d] trav %b erro %b exp %b 0", i, travado, erro, i == 3);
            end
        end
    endtask

    task automatic test_en_gap();
        logic [19:0] snap;
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        snap = {passo, travado, erro, ciclos, falhas};
        cyc(0, 7, 0);
        cyc(0, $urandom_range(0, 7), 0);
        checks++;
        if ({passo, travado, erro, ciclos, falhas} !== snap) begin
            errors++; $display("FAIL en_hold got %h exp %h", {passo, travado, erro, ciclos, falhas}, snap);
        end
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 3, 0);
        checks++;
        if (travado !== 1'b1 || passo !== 6'b001000 || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
            errors++; $display("FAIL en_gap_lock trav %b passo %b exp 1 001000", travado, passo);
        end
    endtask

    task automatic test_saturation();
        bit prev_err = 0;
        cyc(0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 4; b++) cyc(1, b, 0);
            cyc(1, 3, 0);
            checks++;
            if ({passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
                errors++; $display("FAIL sat[%0d] got %h exp %h", k, {passo, travado, erro, ciclos, falhas}, exp_vec());
            end
        end
        checks++;
        if (falhas !== 4'd15) begin
            errors++; $display("FAIL falhas_sat got %0d exp 15", falhas);
        end
        for (int b = 0; b < 4; b++) cyc(1, b, 0);
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 6; j++) begin
                cyc(1, (j + 4) % 6, 0);
                if (erro && prev_err) begin
                    errors++; $display("FAIL erro_twice at cycle %0d", k);
                end
                prev_err = erro;
            end
            if (k == 254) begin
                checks++;
                if (ciclos !== 8'd255) begin
                    errors++; $display("FAIL ciclos_255 got %0d exp 255", ciclos);
                end
            end
        end
        checks++;
        if (ciclos !== 8'd0 || travado !== 1'b1 || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
            errors++; $display("FAIL ciclos_wrap got %0d trav %b exp 0 1", ciclos, travado);
        end
    endtask

    task automatic test_reset_mid_lock();
        cyc(0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) cyc(1, b, 0);
            cyc(1, 5, 0);
        end
        for (int b = 0; b < 4; b++) cyc(1, b, 0);
        for (int k = 0; k < 18; k++) cyc(1, (k + 4) % 6, 0);
        checks++;
        if (ciclos !== 8'd3 || falhas !== 4'd2 || travado !== 1'b1) begin
            errors++; $display("FAIL pre_reset ciclos %0d falhas %0d trav %b exp 3 2 1", ciclos, falhas, travado);
        end
        cyc(1, 4, 1);
        checks++;
        if ({passo, travado, erro, ciclos, falhas} !== 20'd0) begin
            errors++; $display("FAIL mid_lock_reset got %h exp 0", {passo, travado, erro, ciclos, falhas});
        end
        for (int i = 0; i < CONF_N + 1; i++) begin
            cyc(1, (i + 4) % 6, 0);
            checks++;
            if (travado !== (i == CONF_N) || {passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
                errors++; $display("FAIL fresh_lock[%0d] trav %b exp %b", i, travado, i == CONF_N);
            end
        end
    endtask

    task automatic test_random();
        bit prev_err = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            int b;
            b = ($urandom_range(0, 3) != 0) ? (m_ref + 1) % 6 : int'($urandom_range(0, 7));
            cyc($urandom_range(0, 4) != 0, b, $urandom_range(0, 80) == 0);
            checks++;
            if ({passo, travado, erro, ciclos, falhas} !== exp_vec()) begin
                errors++; $display("FAIL random[%0d] got %h exp %h", i, {passo, travado, erro, ciclos, falhas}, exp_vec());
            end
            if (erro && prev_err) begin
                errors++; $display("FAIL random_erro_twice at %0d", i);
            end
            prev_err = erro;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_invalid_locked();
        test_skip_relock();
        test_en_gap();
        test_saturation();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
